// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, forwarding selects and FSM states shared by the execute-stage ALU
package alu_pkg;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
endpackage

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv: one-bit-per-cycle unsigned shift-add multiplier / restoring divider
//   start_i/mode_i (0 mul, 1 div) load a_i/b_i; done_o is high during the last step;
//   lo_o/hi_o: product low/high, or quotient/remainder, valid after done_o
module alu_iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] lo_q, hi_q, b_q;
  logic [CW-1:0] cnt_q;
  logic busy_q, div_q, div_ge;
  logic [WIDTH:0] mul_sum, div_sh, div_diff;
  // lo holds the multiplier (mul) or dividend bits shifting into the remainder (div)
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign div_sh   = {hi_q, lo_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, b_q};
  assign div_ge   = div_sh >= {1'b0, b_q};
  assign done_o   = busy_q && cnt_q == CW'(WIDTH - 1);
  assign lo_o     = lo_q;
  assign hi_o     = hi_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q   <= '0;
      hi_q   <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      div_q  <= 1'b0;
    end else if (start_i) begin
      lo_q   <= a_i;
      hi_q   <= '0;
      b_q    <= b_i;
      cnt_q  <= '0;
      busy_q <= 1'b1;
      div_q  <= mode_i;
    end else if (busy_q) begin
      cnt_q  <= cnt_q + 1'b1;
      busy_q <= !done_o;
      if (div_q) begin
        hi_q <= div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
        lo_q <= {lo_q[WIDTH-2:0], div_ge};
      end else begin
        {hi_q, lo_q} <= {mul_sum, lo_q[WIDTH-1:1]};
      end
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered execute-stage ALU with forwarding, imm sign-extension and iterative MUL/DIVU
//   in_valid/in_ready: accept handshake; out_valid: one-cycle result pulse
//   result/result_hi/zero/illegal/store_data: registered outputs, held between pulses
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 16,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           alu_op,
  input  logic                 alu_src,
  input  logic [WIDTH-1:0]     rs_data,
  input  logic [WIDTH-1:0]     rt_data,
  input  logic [IMM_WIDTH-1:0] imm,
  input  logic [WIDTH-1:0]     ex_mem_fwd,
  input  logic [WIDTH-1:0]     mem_wb_fwd,
  input  logic [1:0]           fwd_a_sel,
  input  logic [1:0]           fwd_b_sel,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     result,
  output logic [WIDTH-1:0]     result_hi,
  output logic                 zero,
  output logic [WIDTH-1:0]     store_data,
  output logic                 illegal
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] op_a, rt_path, op_b, alu_res, md_lo, md_hi;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, store_q, store_d;
  logic zero_q, zero_d, ill_q, ill_d, valid_q, valid_d;
  logic is_md, alu_ill, md_start, md_done;
  assign op_a    = fwd_a_sel == FWD_EXMEM ? ex_mem_fwd : fwd_a_sel == FWD_MEMWB ? mem_wb_fwd : rs_data;
  assign rt_path = fwd_b_sel == FWD_EXMEM ? ex_mem_fwd : fwd_b_sel == FWD_MEMWB ? mem_wb_fwd : rt_data;
  assign op_b    = alu_src ? WIDTH'($signed(imm)) : rt_path;
  assign is_md   = MULDIV_EN && (alu_op == OP_MUL || alu_op == OP_DIVU);
  assign alu_res = alu_op == OP_AND ? op_a & op_b :
                   alu_op == OP_OR  ? op_a | op_b :
                   alu_op == OP_ADD ? op_a + op_b :
                   alu_op == OP_SUB ? op_a - op_b :
                   alu_op == OP_SLT ? WIDTH'($signed(op_a) < $signed(op_b)) :
                   alu_op == OP_NOR ? ~(op_a | op_b) : '0;
  assign alu_ill = !is_md && !(alu_op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR});
  assign in_ready   = state_q == IDLE;
  assign out_valid  = valid_q;
  assign result     = result_q;
  assign result_hi  = hi_q;
  assign zero       = zero_q;
  assign store_data = store_q;
  assign illegal    = ill_q;
  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start_i(md_start),
    .mode_i (alu_op == OP_DIVU),
    .a_i    (op_a),
    .b_i    (op_b),
    .done_o (md_done),
    .lo_o   (md_lo),
    .hi_o   (md_hi)
  );
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    ill_d    = ill_q;
    store_d  = store_q;
    valid_d  = 1'b0;
    md_start = 1'b0;
    if (state_q == IDLE && in_valid) begin
      store_d = rt_path;
      if (is_md) begin
        md_start = 1'b1;
        state_d  = alu_op == OP_MUL ? MUL : DIV;
      end else begin
        result_d = alu_res;
        hi_d     = '0;
        zero_d   = alu_res == '0;
        ill_d    = alu_ill;
        valid_d  = 1'b1;
      end
    end else if ((state_q == MUL || state_q == DIV) && md_done) begin
      state_d = DONE;
    end else if (state_q == DONE) begin
      state_d  = IDLE;
      result_d = md_lo;
      hi_d     = md_hi;
      zero_d   = md_lo == '0;
      ill_d    = 1'b0;
      valid_d  = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      ill_q    <= 1'b0;
      store_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      ill_q    <= ill_d;
      store_q  <= store_d;
      valid_q  <= valid_d;
    end
  end
endmodule
